// File: rtl/instruction_loader_pkg.sv
// Shared types and state encodings for the boot-time instruction loader.
package instruction_loader_pkg;

  localparam int LEN_BITS = 16;

  typedef logic [7:0] byte_t;
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEN_HI = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_CSUM   = 3'd3;
  localparam state_t ST_DONE   = 3'd4;
  localparam state_t ST_ERROR  = 3'd5;

endpackage

// File: rtl/loader_word_packer.sv
// Shifts accepted bytes into a little-endian word and strobes when the word is full.
module loader_word_packer
  import instruction_loader_pkg::*;
#(
  parameter int WORD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  byte_t                data,
  input  logic                 accept,
  output logic                 byte_last,
  output logic                 word_complete,
  output logic [WORD_BITS-1:0] word
);

  localparam int BPW      = WORD_BITS / 8;
  localparam int CNT_BITS = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_BITS-1:0] count;

  assign byte_last = (count == CNT_BITS'(BPW - 1));

  // New bytes enter at the top so the first byte of a word ends up in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      word          <= '0;
      word_complete <= 1'b0;
    end else begin
      word_complete <= accept && byte_last;
      if (accept) begin
        count <= byte_last ? '0 : count + CNT_BITS'(1);
        word  <= (word >> 8) | (WORD_BITS'(data) << (WORD_BITS - 8));
      end
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU in reset.
// Optional trailing XOR checksum byte: define INSTRUCTION_LOADER_CHECKSUM_EN.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter  int WORD_COUNT     = 64,
  parameter  int WORD_BITS      = 32,
  localparam int BYTES_PER_WORD = WORD_BITS / 8,
  localparam int ADDR_BITS      = $clog2(WORD_COUNT * BYTES_PER_WORD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [WORD_BITS-1:0] wr_data,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error
);

  state_t              state;
  byte_t               len_lo;
  logic [LEN_BITS-1:0] n_words;
  logic [LEN_BITS-1:0] word_idx;
  logic [LEN_BITS-1:0] len_full;
  logic                accept;
  logic                data_accept;
  logic                byte_last;
  logic                word_last;

  assign rx_ready    = (state != ST_DONE);
  assign done        = (state == ST_DONE);
  assign error       = (state == ST_ERROR);
  assign accept      = rx_valid && rx_ready;
  assign data_accept = accept && (state == ST_DATA);
  assign len_full    = {rx_data, len_lo};
  assign word_last   = (word_idx == n_words - LEN_BITS'(1));

  loader_word_packer #(
    .WORD_BITS(WORD_BITS)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (rx_data),
    .accept       (data_accept),
    .byte_last    (byte_last),
    .word_complete(wr_en),
    .word         (wr_data)
  );

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  byte_t xor_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_acc <= '0;
    end else if (state == ST_IDLE) begin
      xor_acc <= '0;
    end else if (data_accept) begin
      xor_acc <= xor_acc ^ rx_data;
    end
  end
`endif

  // wr_addr is registered alongside the packer's strobe so address and data line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      len_lo   <= '0;
      n_words  <= '0;
      word_idx <= '0;
      wr_addr  <= '0;
      cpu_hold <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          word_idx <= '0;
          if (accept) begin
            len_lo   <= rx_data;
            cpu_hold <= 1'b1;
            state    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            n_words <= len_full;
            if (len_full == '0)
              state <= ST_DONE;
            else if (len_full > LEN_BITS'(WORD_COUNT))
              state <= ST_ERROR;
            else
              state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept && byte_last) begin
            wr_addr  <= ADDR_BITS'(32'(word_idx) * 32'(BYTES_PER_WORD));
            word_idx <= word_idx + LEN_BITS'(1);
            if (word_last) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
              state <= ST_CSUM;
`else
              state <= ST_DONE;
`endif
            end
          end
        end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (accept)
            state <= (rx_data == xor_acc) ? ST_DONE : ST_ERROR;
        end
`endif
        ST_DONE: begin
          cpu_hold <= 1'b0;
          state    <= ST_IDLE;
        end
        ST_ERROR: begin
          cpu_hold <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader; checksum tests run when
// INSTRUCTION_LOADER_CHECKSUM_EN is defined.
module tb_instruction_loader;

  localparam int WORD_COUNT = 64;
  localparam int WORD_BITS  = 32;
  localparam int ADDR_BITS  = 8;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam int CSUM_EXTRA = 1;
`else
  localparam int CSUM_EXTRA = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [7:0]           rx_data = 8'h00;
  logic                 rx_valid = 1'b0;
  logic                 rx_ready;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [WORD_BITS-1:0] wr_data;
  logic                 cpu_hold;
  logic                 done;
  logic                 error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [ADDR_BITS-1:0] addr_q[$];
  logic [WORD_BITS-1:0] data_q[$];
  int                   wcyc_q[$];
  int                   done_q[$];
  int                   accept_cyc[$];
  logic [7:0]           frame_q[$];
  logic                 prev_done = 1'b0;
  logic                 hold_after_done = 1'b1;
  logic                 hold_at_done = 1'b0;
  logic                 ready_at_done = 1'b1;

  instruction_loader #(
    .WORD_COUNT(WORD_COUNT),
    .WORD_BITS (WORD_BITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Logs writes and done pulses with the cycle number they were seen in.
  always @(negedge clk) begin
    if (prev_done) hold_after_done = cpu_hold;
    if (wr_en) begin
      addr_q.push_back(wr_addr);
      data_q.push_back(wr_data);
      wcyc_q.push_back(cyc);
    end
    if (done) begin
      done_q.push_back(cyc);
      hold_at_done = cpu_hold;
      ready_at_done = rx_ready;
    end
    prev_done = done;
  end

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic clear_logs();
    addr_q.delete();
    data_q.delete();
    wcyc_q.delete();
    done_q.delete();
    accept_cyc.delete();
    hold_after_done = 1'b1;
    hold_at_done = 1'b0;
    ready_at_done = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send_byte(input logic [7:0] b);
    logic took = 1'b0;
    int tries = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!took && tries < 20) begin
      took = rx_ready;
      @(posedge clk);
      @(negedge clk);
      tries++;
    end
    rx_valid = 1'b0;
    if (took) begin
      accept_cyc.push_back(cyc);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL send_byte_timeout byte %02h not accepted within 20 cycles", b);
    end
  endtask

  task automatic send_frame(input bit gapped);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gapped) idle(1);
      send_byte(frame_q[i]);
      if (i >= 2) x ^= frame_q[i];
    end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    if (frame_q.size() > 2) begin
      if (gapped) idle(1);
      send_byte(x);
    end
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    clear_logs();
  endtask

  task automatic test_reset();
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_rx_ready got %b want 1", rx_ready); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("[TB] FAIL reset_cpu_hold got %b want 1", cpu_hold); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en got %b want 0", wr_en); end
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_wr_addr got %h want 00", wr_addr); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_wr_data got %h want 0", wr_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got %b want 0", error); end
  endtask

  task automatic check_two_word(input string tag);
    checks++; if (addr_q.size() != 2) begin errors++; $display("[TB] FAIL %s_write_count got %0d want 2", tag, addr_q.size()); end
    if (addr_q.size() == 2 && accept_cyc.size() >= 10) begin
      checks++; if (addr_q[0] !== 8'h00) begin errors++; $display("[TB] FAIL %s_addr0 got %h want 00", tag, addr_q[0]); end
      checks++; if (data_q[0] !== 32'h44332211) begin errors++; $display("[TB] FAIL %s_data0 got %h want 44332211", tag, data_q[0]); end
      checks++; if (addr_q[1] !== 8'h04) begin errors++; $display("[TB] FAIL %s_addr1 got %h want 04", tag, addr_q[1]); end
      checks++; if (data_q[1] !== 32'h88776655) begin errors++; $display("[TB] FAIL %s_data1 got %h want 88776655", tag, data_q[1]); end
      checks++; if (wcyc_q[0] != accept_cyc[5]) begin errors++; $display("[TB] FAIL %s_wr0_timing got cycle %0d want %0d", tag, wcyc_q[0], accept_cyc[5]); end
      checks++; if (wcyc_q[1] != accept_cyc[9]) begin errors++; $display("[TB] FAIL %s_wr1_timing got cycle %0d want %0d", tag, wcyc_q[1], accept_cyc[9]); end
    end
    checks++; if (done_q.size() != 1) begin errors++; $display("[TB] FAIL %s_done_count got %0d want 1", tag, done_q.size()); end
    if (done_q.size() == 1 && accept_cyc.size() == 10 + CSUM_EXTRA) begin
      checks++; if (done_q[0] != accept_cyc[9 + CSUM_EXTRA]) begin errors++; $display("[TB] FAIL %s_done_timing got cycle %0d want %0d", tag, done_q[0], accept_cyc[9 + CSUM_EXTRA]); end
    end
    checks++; if (hold_at_done !== 1'b1) begin errors++; $display("[TB] FAIL %s_hold_at_done got %b want 1", tag, hold_at_done); end
    checks++; if (ready_at_done !== 1'b0) begin errors++; $display("[TB] FAIL %s_ready_at_done got %b want 0", tag, ready_at_done); end
    checks++; if (hold_after_done !== 1'b0) begin errors++; $display("[TB] FAIL %s_hold_after_done got %b want 0", tag, hold_after_done); end
  endtask

  task automatic test_two_word();
    clear_logs();
    frame_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(1'b0);
    idle(4);
    check_two_word("b2b");
  endtask

  task automatic test_gapped();
    clear_logs();
    frame_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(1'b1);
    idle(4);
    check_two_word("gapped");
  endtask

  task automatic test_zero_len();
    clear_logs();
    frame_q = '{8'h00, 8'h00};
    send_frame(1'b0);
    idle(3);
    checks++; if (addr_q.size() != 0) begin errors++; $display("[TB] FAIL zero_len_writes got %0d want 0", addr_q.size()); end
    checks++; if (done_q.size() != 1) begin errors++; $display("[TB] FAIL zero_len_done_count got %0d want 1", done_q.size()); end
    if (done_q.size() == 1 && accept_cyc.size() == 2) begin
      checks++; if (done_q[0] != accept_cyc[1]) begin errors++; $display("[TB] FAIL zero_len_done_timing got %0d want %0d", done_q[0], accept_cyc[1]); end
    end
  endtask

  task automatic test_len_error();
    clear_logs();
    send_byte(8'h41);
    send_byte(8'h00);
    checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL len_error_rise got %b want 1", error); end
    for (int i = 0; i < 10; i++) send_byte(8'(8'hA0 + i));
    idle(2);
    checks++; if (accept_cyc.size() != 12) begin errors++; $display("[TB] FAIL len_error_accepts got %0d want 12", accept_cyc.size()); end
    checks++; if (addr_q.size() != 0) begin errors++; $display("[TB] FAIL len_error_writes got %0d want 0", addr_q.size()); end
    checks++; if (done_q.size() != 0) begin errors++; $display("[TB] FAIL len_error_done got %0d want 0", done_q.size()); end
    checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL len_error_sticky got %b want 1", error); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("[TB] FAIL len_error_hold got %b want 1", cpu_hold); end
    do_reset();
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL len_error_cleared got %b want 0", error); end
  endtask

  task automatic test_full_image();
    clear_logs();
    frame_q.delete();
    frame_q.push_back(8'h40);
    frame_q.push_back(8'h00);
    for (int i = 0; i < 256; i++) frame_q.push_back(8'(i));
    send_frame(1'b0);
    idle(4);
    checks++; if (addr_q.size() != 64) begin errors++; $display("[TB] FAIL full_write_count got %0d want 64", addr_q.size()); end
    if (addr_q.size() == 64) begin
      checks++; if (addr_q[10] !== 8'h28 || data_q[10] !== 32'h2B2A2928) begin errors++; $display("[TB] FAIL full_word10 got %h/%h want 28/2b2a2928", addr_q[10], data_q[10]); end
      checks++; if (addr_q[63] !== 8'hFC) begin errors++; $display("[TB] FAIL full_last_addr got %h want fc", addr_q[63]); end
      checks++; if (data_q[63] !== 32'hFFFEFDFC) begin errors++; $display("[TB] FAIL full_last_data got %h want fffefdfc", data_q[63]); end
    end
    checks++; if (done_q.size() != 1 || error !== 1'b0) begin errors++; $display("[TB] FAIL full_done got %0d err %b want 1 err 0", done_q.size(), error); end
  endtask

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_logs();
    frame_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    for (int i = 0; i < 7; i++) send_byte(frame_q[i]);
    idle(3);
    checks++; if (addr_q.size() != 1 || data_q[0] !== 32'h44332211 || addr_q[0] !== 8'h00) begin errors++; $display("[TB] FAIL csum_good_write got %0d writes want 1 at 00 = 44332211", addr_q.size()); end
    checks++; if (done_q.size() != 1) begin errors++; $display("[TB] FAIL csum_good_done got %0d want 1", done_q.size()); end
    if (done_q.size() == 1 && accept_cyc.size() == 7) begin
      checks++; if (done_q[0] != accept_cyc[6]) begin errors++; $display("[TB] FAIL csum_good_done_timing got %0d want %0d", done_q[0], accept_cyc[6]); end
    end
    clear_logs();
    frame_q[6] = 8'h45;
    for (int i = 0; i < 6; i++) send_byte(frame_q[i]);
    send_byte(frame_q[6]);
    checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL csum_bad_error got %b want 1", error); end
    idle(3);
    checks++; if (addr_q.size() != 1 || data_q[0] !== 32'h44332211) begin errors++; $display("[TB] FAIL csum_bad_write got %0d writes want 1", addr_q.size()); end
    checks++; if (done_q.size() != 0) begin errors++; $display("[TB] FAIL csum_bad_done got %0d want 0", done_q.size()); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("[TB] FAIL csum_bad_hold got %b want 1", cpu_hold); end
    do_reset();
  endtask
`endif

  task automatic test_midframe_reset();
    clear_logs();
    send_byte(8'h03);
    send_byte(8'h00);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    rst_n = 1'b0;
    #1;
    checks++; if (addr_q.size() != 1 || addr_q[0] !== 8'h00 || data_q[0] !== 32'h04030201) begin errors++; $display("[TB] FAIL midreset_writes got %0d writes want 1 at 00 = 04030201", addr_q.size()); end
    checks++; if ({rx_ready, cpu_hold, wr_en, done, error} !== 5'b11000) begin errors++; $display("[TB] FAIL midreset_ctrl got %b want 11000", {rx_ready, cpu_hold, wr_en, done, error}); end
    checks++; if (wr_addr !== 8'h00 || wr_data !== 32'h0) begin errors++; $display("[TB] FAIL midreset_bus got %h/%h want 00/0", wr_addr, wr_data); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    clear_logs();
    frame_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(1'b0);
    idle(4);
    checks++; if (addr_q.size() != 1 || addr_q[0] !== 8'h00 || data_q[0] !== 32'hDDCCBBAA) begin errors++; $display("[TB] FAIL reload_write got %0d writes want 1 at 00 = ddccbbaa", addr_q.size()); end
    checks++; if (done_q.size() != 1 || cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL reload_done got %0d hold %b want 1 hold 0", done_q.size(), cpu_hold); end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    idle(2);
    test_two_word();
    test_zero_len();
    test_len_error();
    test_gapped();
    test_full_image();
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
